// File: rtl/commit_queue.sv
`timescale 1ns / 1ps
// commit_queue: DEPTH-entry in-order commit queue fed by execute over a ready/valid handshake.
// The head entry retires a register writeback, a data FIFO store, an exception, a jump
// redirect or a CSR write (issued over AXI-Lite with AW and W in parallel). A 64-bit
// retired-instruction counter is kept alongside.
//
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   execute_*                   entry offered by execute (valid/ready handshake)
//   datafifo_*                  store push towards the data FIFO (full is back-pressure)
//   exception_*_out             exception strobe with cause, value and PC
//   rd_*_out                    register writeback strobe
//   commit_valid                head entry retired this cycle
//   pipeline_flush/pipeline_pc  discard younger work and refetch from pipeline_pc
//   active_rd                   one-hot of queued, unretired destination registers
//   instret                     retired-instruction count
//   axil_csr_*                  AXI-Lite write channel for CSR writes
module commit_queue #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned DEPTH         = 2,
  parameter int unsigned EXC_CSR_FAULT = 2
) (
  input  logic            clk,
  input  logic            reset,

  input  logic            execute_valid,
  output logic            execute_ready,
  input  logic [4:0]      execute_rd,
  input  logic [XLEN-1:0] execute_rd_val,
  input  logic [XLEN-1:0] execute_inst_pc,
  input  logic [XLEN-1:0] execute_jump_pc,
  input  logic            execute_jump_valid,
  input  logic [5:0]      execute_exception_num,
  input  logic [XLEN-1:0] execute_exception_val,
  input  logic            execute_exception_valid,
  input  logic [XLEN-1:0] execute_store_addr,
  input  logic [XLEN-1:0] execute_store_val,
  input  logic [1:0]      execute_store_size,
  input  logic            execute_store_valid,
  input  logic [11:0]     execute_csr_write_addr,
  input  logic [XLEN-1:0] execute_csr_write_val,
  input  logic            execute_csr_write_valid,

  input  logic            datafifo_full,
  output logic [XLEN-1:0] datafifo_addr_out,
  output logic [XLEN-1:0] datafifo_val_out,
  output logic [1:0]      datafifo_size_out,
  output logic            datafifo_valid_out,

  output logic [5:0]      exception_num_out,
  output logic [XLEN-1:0] exception_val_out,
  output logic [XLEN-1:0] exception_pc_out,
  output logic            exception_valid_out,

  output logic [4:0]      rd_out,
  output logic [XLEN-1:0] rd_val_out,
  output logic            rd_valid_out,

  output logic            commit_valid,
  output logic            pipeline_flush,
  output logic [XLEN-1:0] pipeline_pc,
  output logic [31:0]     active_rd,
  output logic [63:0]     instret,

  output logic [11:0]     axil_csr_awaddr,
  output logic            axil_csr_awvalid,
  input  logic            axil_csr_awready,
  output logic [XLEN-1:0] axil_csr_wdata,
  output logic            axil_csr_wvalid,
  input  logic            axil_csr_wready,
  input  logic [1:0]      axil_csr_bresp,
  input  logic            axil_csr_bvalid,
  output logic            axil_csr_bready
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] rd_val;
    logic [XLEN-1:0] inst_pc;
    logic [XLEN-1:0] jump_pc;
    logic            jump_valid;
    logic [5:0]      exc_num;
    logic [XLEN-1:0] exc_val;
    logic            exc_valid;
    logic [XLEN-1:0] st_addr;
    logic [XLEN-1:0] st_val;
    logic [1:0]      st_size;
    logic            st_valid;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_val;
    logic            csr_valid;
  } entry_t;

  typedef enum logic [2:0] {
    KindNodata,
    KindException,
    KindWaitFifo,
    KindWaitCsrw,
    KindCommit
  } head_kind_e;

  typedef enum logic [1:0] {
    StIdle,
    StAwW,
    StBresp,
    StCsrCommit
  } csr_state_e;

  // Queue storage and pointers
  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic [63:0]     instret_q, instret_d;

  // CSR write sequencing
  csr_state_e      csr_state_q, csr_state_d;
  logic            aw_done_q, aw_done_d;
  logic            w_done_q, w_done_d;
  logic            csr_fault_q, csr_fault_d;

  entry_t          head;
  entry_t          entry_in;
  head_kind_e      head_kind;
  logic            push;
  logic            pop;
  logic            aw_hs;
  logic            w_hs;
  logic [PtrW-1:0] ar_idx;

  assign head = mem_q[head_q];

  always_comb begin
    entry_in            = '0;
    entry_in.rd         = execute_rd;
    entry_in.rd_val     = execute_rd_val;
    entry_in.inst_pc    = execute_inst_pc;
    entry_in.jump_pc    = execute_jump_pc;
    entry_in.jump_valid = execute_jump_valid;
    entry_in.exc_num    = execute_exception_num;
    entry_in.exc_val    = execute_exception_val;
    entry_in.exc_valid  = execute_exception_valid;
    entry_in.st_addr    = execute_store_addr;
    entry_in.st_val     = execute_store_val;
    entry_in.st_size    = execute_store_size;
    entry_in.st_valid   = execute_store_valid;
    entry_in.csr_addr   = execute_csr_write_addr;
    entry_in.csr_val    = execute_csr_write_val;
    entry_in.csr_valid  = execute_csr_write_valid;
  end

  // Classify the head entry; earlier tests win.
  always_comb begin
    if (count_q == '0) begin
      head_kind = KindNodata;
    end else if (head.exc_valid) begin
      head_kind = KindException;
    end else if (head.st_valid && datafifo_full) begin
      head_kind = KindWaitFifo;
    end else if (head.csr_valid) begin
      head_kind = KindWaitCsrw;
    end else begin
      head_kind = KindCommit;
    end
  end

  // Retirement outputs
  always_comb begin
    commit_valid        = 1'b0;
    pipeline_flush      = 1'b0;
    pipeline_pc         = '0;
    rd_out              = '0;
    rd_val_out          = '0;
    rd_valid_out        = 1'b0;
    datafifo_addr_out   = '0;
    datafifo_val_out    = '0;
    datafifo_size_out   = '0;
    datafifo_valid_out  = 1'b0;
    exception_num_out   = '0;
    exception_val_out   = '0;
    exception_pc_out    = '0;
    exception_valid_out = 1'b0;
    unique case (head_kind)
      KindException: begin
        commit_valid        = 1'b1;
        pipeline_flush      = 1'b1;
        exception_valid_out = 1'b1;
        exception_num_out   = head.exc_num;
        exception_val_out   = head.exc_val;
        exception_pc_out    = head.inst_pc;
      end
      KindCommit: begin
        commit_valid = 1'b1;
        if (head.rd != 5'd0) begin
          rd_valid_out = 1'b1;
          rd_out       = head.rd;
          rd_val_out   = head.rd_val;
        end
        if (head.st_valid) begin
          datafifo_valid_out = 1'b1;
          datafifo_addr_out  = head.st_addr;
          datafifo_val_out   = head.st_val;
          datafifo_size_out  = head.st_size;
        end
        if (head.jump_valid) begin
          pipeline_flush = 1'b1;
          pipeline_pc    = head.jump_pc;
        end
      end
      KindWaitCsrw: begin
        if (csr_state_q == StCsrCommit) begin
          commit_valid = 1'b1;
          if (csr_fault_q) begin
            exception_valid_out = 1'b1;
            exception_num_out   = 6'(EXC_CSR_FAULT);
            exception_pc_out    = head.inst_pc;
            pipeline_flush      = 1'b1;
          end else if (head.rd != 5'd0) begin
            rd_valid_out = 1'b1;
            rd_out       = head.rd;
            rd_val_out   = head.rd_val;
          end
        end
      end
      default: ;
    endcase
  end

  // Retiring head frees its slot in the same cycle.
  assign execute_ready = (count_q < CntW'(DEPTH)) || commit_valid;
  assign push          = execute_valid && execute_ready;
  assign pop           = commit_valid;

  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[tail_q] = entry_in;
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pipeline_flush) begin
      // Flush empties the queue and drops a same-cycle push.
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PtrW'(pop);
      tail_d  = tail_q + PtrW'(push);
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  assign instret_d = (commit_valid && !exception_valid_out) ? instret_q + 64'd1 : instret_q;
  assign instret   = instret_q;

  always_comb begin
    active_rd = '0;
    ar_idx    = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      ar_idx = head_q + PtrW'(k);
      if ((CntW'(k) < count_q) && !((k == 0) && commit_valid) && (mem_q[ar_idx].rd != 5'd0)) begin
        active_rd[mem_q[ar_idx].rd] = 1'b1;
      end
    end
  end

  // AXI-Lite CSR write: AW and W raised together, each dropped on its own handshake.
  assign axil_csr_awvalid = (csr_state_q == StAwW) && !aw_done_q;
  assign axil_csr_wvalid  = (csr_state_q == StAwW) && !w_done_q;
  assign axil_csr_awaddr  = axil_csr_awvalid ? head.csr_addr : '0;
  assign axil_csr_wdata   = axil_csr_wvalid ? head.csr_val : '0;
  assign axil_csr_bready  = (csr_state_q == StBresp);
  assign aw_hs            = axil_csr_awvalid && axil_csr_awready;
  assign w_hs             = axil_csr_wvalid && axil_csr_wready;

  always_comb begin
    csr_state_d = csr_state_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    csr_fault_d = csr_fault_q;
    unique case (csr_state_q)
      StIdle: begin
        if (head_kind == KindWaitCsrw) begin
          csr_state_d = StAwW;
          aw_done_d   = 1'b0;
          w_done_d    = 1'b0;
        end
      end
      StAwW: begin
        aw_done_d = aw_done_q || aw_hs;
        w_done_d  = w_done_q || w_hs;
        if (aw_done_d && w_done_d) begin
          csr_state_d = StBresp;
        end
      end
      StBresp: begin
        if (axil_csr_bvalid) begin
          csr_fault_d = (axil_csr_bresp != 2'b00);
          csr_state_d = StCsrCommit;
        end
      end
      StCsrCommit: begin
        csr_state_d = StIdle;
      end
      default: begin
        csr_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      instret_q   <= '0;
      csr_state_q <= StIdle;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      csr_fault_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      instret_q   <= instret_d;
      csr_state_q <= csr_state_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      csr_fault_q <= csr_fault_d;
    end
  end

  // Payload storage needs no reset: every use is qualified by count_q.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_commit_queue.sv
`timescale 1ns / 1ps
// Directed bench for commit_queue with writeback/store/exception scoreboards.
module tb_commit_queue;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 2;

  logic            clk;
  logic            reset;
  logic            execute_valid;
  logic            execute_ready;
  logic [4:0]      execute_rd;
  logic [XLEN-1:0] execute_rd_val;
  logic [XLEN-1:0] execute_inst_pc;
  logic [XLEN-1:0] execute_jump_pc;
  logic            execute_jump_valid;
  logic [5:0]      execute_exception_num;
  logic [XLEN-1:0] execute_exception_val;
  logic            execute_exception_valid;
  logic [XLEN-1:0] execute_store_addr;
  logic [XLEN-1:0] execute_store_val;
  logic [1:0]      execute_store_size;
  logic            execute_store_valid;
  logic [11:0]     execute_csr_write_addr;
  logic [XLEN-1:0] execute_csr_write_val;
  logic            execute_csr_write_valid;
  logic            datafifo_full;
  logic [XLEN-1:0] datafifo_addr_out;
  logic [XLEN-1:0] datafifo_val_out;
  logic [1:0]      datafifo_size_out;
  logic            datafifo_valid_out;
  logic [5:0]      exception_num_out;
  logic [XLEN-1:0] exception_val_out;
  logic [XLEN-1:0] exception_pc_out;
  logic            exception_valid_out;
  logic [4:0]      rd_out;
  logic [XLEN-1:0] rd_val_out;
  logic            rd_valid_out;
  logic            commit_valid;
  logic            pipeline_flush;
  logic [XLEN-1:0] pipeline_pc;
  logic [31:0]     active_rd;
  logic [63:0]     instret;
  logic [11:0]     axil_csr_awaddr;
  logic            axil_csr_awvalid;
  logic            axil_csr_awready;
  logic [XLEN-1:0] axil_csr_wdata;
  logic            axil_csr_wvalid;
  logic            axil_csr_wready;
  logic [1:0]      axil_csr_bresp;
  logic            axil_csr_bvalid;
  logic            axil_csr_bready;

  commit_queue #(
    .XLEN         (XLEN),
    .DEPTH        (DEPTH),
    .EXC_CSR_FAULT(2)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .execute_valid          (execute_valid),
    .execute_ready          (execute_ready),
    .execute_rd             (execute_rd),
    .execute_rd_val         (execute_rd_val),
    .execute_inst_pc        (execute_inst_pc),
    .execute_jump_pc        (execute_jump_pc),
    .execute_jump_valid     (execute_jump_valid),
    .execute_exception_num  (execute_exception_num),
    .execute_exception_val  (execute_exception_val),
    .execute_exception_valid(execute_exception_valid),
    .execute_store_addr     (execute_store_addr),
    .execute_store_val      (execute_store_val),
    .execute_store_size     (execute_store_size),
    .execute_store_valid    (execute_store_valid),
    .execute_csr_write_addr (execute_csr_write_addr),
    .execute_csr_write_val  (execute_csr_write_val),
    .execute_csr_write_valid(execute_csr_write_valid),
    .datafifo_full          (datafifo_full),
    .datafifo_addr_out      (datafifo_addr_out),
    .datafifo_val_out       (datafifo_val_out),
    .datafifo_size_out      (datafifo_size_out),
    .datafifo_valid_out     (datafifo_valid_out),
    .exception_num_out      (exception_num_out),
    .exception_val_out      (exception_val_out),
    .exception_pc_out       (exception_pc_out),
    .exception_valid_out    (exception_valid_out),
    .rd_out                 (rd_out),
    .rd_val_out             (rd_val_out),
    .rd_valid_out           (rd_valid_out),
    .commit_valid           (commit_valid),
    .pipeline_flush         (pipeline_flush),
    .pipeline_pc            (pipeline_pc),
    .active_rd              (active_rd),
    .instret                (instret),
    .axil_csr_awaddr        (axil_csr_awaddr),
    .axil_csr_awvalid       (axil_csr_awvalid),
    .axil_csr_awready       (axil_csr_awready),
    .axil_csr_wdata         (axil_csr_wdata),
    .axil_csr_wvalid        (axil_csr_wvalid),
    .axil_csr_wready        (axil_csr_wready),
    .axil_csr_bresp         (axil_csr_bresp),
    .axil_csr_bvalid        (axil_csr_bvalid),
    .axil_csr_bready        (axil_csr_bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [4:0] rd; logic [31:0] val; } wb_t;
  typedef struct { logic [31:0] addr; logic [31:0] val; logic [1:0] size; } st_t;
  typedef struct { logic [5:0] num; logic [31:0] val; logic [31:0] pc; } exc_t;

  wb_t  wb_q[$];
  st_t  st_q[$];
  exc_t exc_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Compare every retirement strobe against the matching scoreboard.
  task automatic observe();
    wb_t  w;
    st_t  s;
    exc_t e;
    if (rd_valid_out) begin
      check("wb_pending", 64'(wb_q.size() > 0), 64'd1);
      if (wb_q.size() > 0) begin
        w = wb_q.pop_front();
        check("wb_rd", 64'(rd_out), 64'(w.rd));
        check("wb_val", 64'(rd_val_out), 64'(w.val));
      end
    end
    if (datafifo_valid_out) begin
      check("st_pending", 64'(st_q.size() > 0), 64'd1);
      if (st_q.size() > 0) begin
        s = st_q.pop_front();
        check("st_addr", 64'(datafifo_addr_out), 64'(s.addr));
        check("st_val", 64'(datafifo_val_out), 64'(s.val));
        check("st_size", 64'(datafifo_size_out), 64'(s.size));
      end
    end
    if (exception_valid_out) begin
      check("exc_pending", 64'(exc_q.size() > 0), 64'd1);
      if (exc_q.size() > 0) begin
        e = exc_q.pop_front();
        check("exc_num", 64'(exception_num_out), 64'(e.num));
        check("exc_val", 64'(exception_val_out), 64'(e.val));
        check("exc_pc", 64'(exception_pc_out), 64'(e.pc));
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    observe();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_entry();
    execute_valid           = 1'b0;
    execute_rd              = '0;
    execute_rd_val          = '0;
    execute_inst_pc         = '0;
    execute_jump_pc         = '0;
    execute_jump_valid      = 1'b0;
    execute_exception_num   = '0;
    execute_exception_val   = '0;
    execute_exception_valid = 1'b0;
    execute_store_addr      = '0;
    execute_store_val       = '0;
    execute_store_size      = '0;
    execute_store_valid     = 1'b0;
    execute_csr_write_addr  = '0;
    execute_csr_write_val   = '0;
    execute_csr_write_valid = 1'b0;
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic [31:0] val, input logic [31:0] pc);
    clear_entry();
    execute_valid   = 1'b1;
    execute_rd      = rd;
    execute_rd_val  = val;
    execute_inst_pc = pc;
  endtask

  task automatic drive_csr(input logic [4:0] rd, input logic [31:0] rv, input logic [11:0] addr,
                           input logic [31:0] cv, input logic [31:0] pc);
    drive_alu(rd, rv, pc);
    execute_csr_write_addr  = addr;
    execute_csr_write_val   = cv;
    execute_csr_write_valid = 1'b1;
  endtask

  task automatic drive_store(input logic [31:0] addr, input logic [31:0] val, input logic [1:0] sz);
    drive_alu(5'd0, 32'd0, 32'h40);
    execute_store_addr  = addr;
    execute_store_val   = val;
    execute_store_size  = sz;
    execute_store_valid = 1'b1;
  endtask

  initial begin
    reset            = 1'b0;
    datafifo_full    = 1'b0;
    axil_csr_awready = 1'b0;
    axil_csr_wready  = 1'b0;
    axil_csr_bresp   = 2'b00;
    axil_csr_bvalid  = 1'b0;
    clear_entry();

    // Reset state
    sample();
    check("rst_ready", 64'(execute_ready), 64'd1);
    check("rst_commit", 64'(commit_valid), 64'd0);
    check("rst_instret", instret, 64'd0);
    check("rst_active_rd", 64'(active_rd), 64'd0);
    check("rst_awvalid", 64'(axil_csr_awvalid), 64'd0);
    check("rst_bready", 64'(axil_csr_bready), 64'd0);
    step();
    reset = 1'b1;

    // Three back-to-back ALU entries
    drive_alu(5'd5, 32'h11, 32'h0);
    wb_q.push_back('{rd: 5'd5, val: 32'h11});
    sample(); check("t1_ready0", 64'(execute_ready), 64'd1); step();
    drive_alu(5'd6, 32'h22, 32'h4);
    wb_q.push_back('{rd: 5'd6, val: 32'h22});
    sample(); check("t1_ready1", 64'(execute_ready), 64'd1);
    check("t1_wb_x5", 64'(rd_valid_out), 64'd1); step();
    drive_alu(5'd0, 32'h33, 32'h8);
    sample(); check("t1_ready2", 64'(execute_ready), 64'd1);
    check("t1_wb_x6", 64'(rd_valid_out), 64'd1); step();
    clear_entry();
    sample(); check("t1_commit_x0", 64'(commit_valid), 64'd1);
    check("t1_no_wb_x0", 64'(rd_valid_out), 64'd0); step();
    sample(); check("t1_instret", instret, 64'd3); step();

    // Store held by a full data FIFO
    datafifo_full = 1'b1;
    drive_store(32'h40, 32'hdead, 2'd2);
    sample(); check("t2_ready0", 64'(execute_ready), 64'd1); step();
    drive_alu(5'd7, 32'h77, 32'h44);
    wb_q.push_back('{rd: 5'd7, val: 32'h77});
    sample(); check("t2_hold_c1", 64'(commit_valid), 64'd0); step();
    clear_entry();
    for (int i = 0; i < 3; i++) begin
      sample();
      check("t2_hold", 64'(commit_valid), 64'd0);
      check("t2_full_ready", 64'(execute_ready), 64'd0);
      check("t2_no_push", 64'(datafifo_valid_out), 64'd0);
      step();
    end
    datafifo_full = 1'b0;
    st_q.push_back('{addr: 32'h40, val: 32'hdead, size: 2'd2});
    sample(); check("t2_store_pulse", 64'(datafifo_valid_out), 64'd1); step();
    sample(); check("t2_commit_f", 64'(commit_valid), 64'd1); step();
    sample(); check("t2_idle", 64'(commit_valid), 64'd0);
    check("t2_instret", instret, 64'd5); step();

    // Jump flushes a queued younger entry and a same-cycle push
    datafifo_full = 1'b1;
    drive_store(32'h80, 32'h5, 2'd0);
    sample(); step();
    drive_alu(5'd1, 32'h104, 32'h50);
    execute_jump_pc    = 32'h100;
    execute_jump_valid = 1'b1;
    sample(); check("t3_ready_j", 64'(execute_ready), 64'd1); step();
    datafifo_full = 1'b0;
    st_q.push_back('{addr: 32'h80, val: 32'h5, size: 2'd0});
    drive_alu(5'd9, 32'h99, 32'h54);
    sample(); check("t3_commit_s", 64'(commit_valid), 64'd1);
    check("t3_ready_y", 64'(execute_ready), 64'd1); step();
    wb_q.push_back('{rd: 5'd1, val: 32'h104});
    drive_alu(5'd10, 32'haa, 32'h58);
    sample(); check("t3_flush", 64'(pipeline_flush), 64'd1);
    check("t3_pc", 64'(pipeline_pc), 64'h100);
    check("t3_active_y", 64'(active_rd), 64'h200); step();
    clear_entry();
    sample(); check("t3_empty_commit", 64'(commit_valid), 64'd0);
    check("t3_empty_active", 64'(active_rd), 64'd0); step();
    sample(); check("t3_still_empty", 64'(commit_valid), 64'd0);
    check("t3_instret", instret, 64'd7); step();

    // CSR write, W accepted one cycle before AW
    drive_csr(5'd3, 32'h1234, 12'h300, 32'habc, 32'h60);
    sample(); step();
    clear_entry();
    sample(); check("t4_active", 64'(active_rd), 64'h8);
    check("t4_aw_idle", 64'(axil_csr_awvalid), 64'd0); step();
    axil_csr_wready = 1'b1;
    sample(); check("t4_awvalid0", 64'(axil_csr_awvalid), 64'd1);
    check("t4_wvalid0", 64'(axil_csr_wvalid), 64'd1);
    check("t4_awaddr", 64'(axil_csr_awaddr), 64'h300);
    check("t4_wdata", 64'(axil_csr_wdata), 64'habc); step();
    axil_csr_wready  = 1'b0;
    axil_csr_awready = 1'b1;
    sample(); check("t4_awvalid1", 64'(axil_csr_awvalid), 64'd1);
    check("t4_wvalid1", 64'(axil_csr_wvalid), 64'd0); step();
    axil_csr_awready = 1'b0;
    sample(); check("t4_bready", 64'(axil_csr_bready), 64'd1);
    check("t4_aw_drop", 64'(axil_csr_awvalid), 64'd0);
    check("t4_active_b", 64'(active_rd), 64'h8); step();
    axil_csr_bvalid = 1'b1;
    axil_csr_bresp  = 2'b00;
    sample(); check("t4_no_commit_b", 64'(commit_valid), 64'd0); step();
    axil_csr_bvalid = 1'b0;
    wb_q.push_back('{rd: 5'd3, val: 32'h1234});
    sample(); check("t4_commit", 64'(commit_valid), 64'd1);
    check("t4_active_clr", 64'(active_rd), 64'd0); step();
    sample(); check("t4_instret", instret, 64'd8); step();

    // CSR write faulting with SLVERR
    drive_csr(5'd4, 32'h55, 12'h305, 32'h1, 32'h200);
    sample(); step();
    clear_entry();
    sample(); step();
    axil_csr_awready = 1'b1;
    axil_csr_wready  = 1'b1;
    sample(); check("t5_both_valid", 64'({axil_csr_awvalid, axil_csr_wvalid}), 64'd3); step();
    axil_csr_awready = 1'b0;
    axil_csr_wready  = 1'b0;
    axil_csr_bvalid  = 1'b1;
    axil_csr_bresp   = 2'b10;
    sample(); check("t5_bready", 64'(axil_csr_bready), 64'd1); step();
    axil_csr_bvalid = 1'b0;
    axil_csr_bresp  = 2'b00;
    exc_q.push_back('{num: 6'd2, val: 32'd0, pc: 32'h200});
    sample(); check("t5_exc", 64'(exception_valid_out), 64'd1);
    check("t5_flush", 64'(pipeline_flush), 64'd1);
    check("t5_no_wb", 64'(rd_valid_out), 64'd0); step();
    sample(); check("t5_instret", instret, 64'd8); step();

    // Asynchronous reset in the middle of BRESP
    drive_csr(5'd8, 32'h88, 12'h340, 32'h1, 32'h300);
    sample(); step();
    drive_alu(5'd11, 32'hbb, 32'h304);
    sample(); check("t6_ready_push", 64'(execute_ready), 64'd1); step();
    clear_entry();
    axil_csr_awready = 1'b1;
    axil_csr_wready  = 1'b1;
    sample(); step();
    axil_csr_awready = 1'b0;
    axil_csr_wready  = 1'b0;
    sample(); check("t6_bready_pre", 64'(axil_csr_bready), 64'd1);
    check("t6_active_pre", 64'(active_rd), 64'h900);
    check("t6_full", 64'(execute_ready), 64'd0);
    #2 reset = 1'b0;
    #1;
    check("t6_bready_rst", 64'(axil_csr_bready), 64'd0);
    check("t6_instret_rst", instret, 64'd0);
    check("t6_ready_rst", 64'(execute_ready), 64'd1);
    check("t6_active_rst", 64'(active_rd), 64'd0);
    check("t6_commit_rst", 64'(commit_valid), 64'd0);
    step();
    reset = 1'b1;
    sample(); check("t6_idle_commit", 64'(commit_valid), 64'd0);
    check("t6_idle_aw", 64'(axil_csr_awvalid), 64'd0); step();

    check("sb_drained", 64'(wb_q.size() + st_q.size() + exc_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/commit_queue.md
Name: commit_queue

Overview:
Parametrised commit stage that replaces the single-entry commit register with a DEPTH-entry in-order queue, and gives execute a ready/valid handshake instead of the stall output. The head entry retires register writebacks, stores to the data FIFO, exceptions, jumps and CSR writes. CSR writes go over AXI-Lite with AW and W issued in parallel. The block also keeps a 64-bit retired-instruction counter.

Parameters:
XLEN, 32, data/address width of rd values, PCs, store and CSR data
DEPTH, 2, queue entries; power of two, >=2
EXC_CSR_FAULT, 2, exception number reported when a CSR write returns a non-OKAY bresp

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
execute_valid  in  1  execute offers an entry
execute_ready  out  1  queue can accept an entry
execute_rd  in  5  destination register
execute_rd_val  in  XLEN  destination value
execute_inst_pc  in  XLEN  instruction PC
execute_jump_pc  in  XLEN  jump target
execute_jump_valid  in  1  entry redirects fetch
execute_exception_num  in  6  exception cause
execute_exception_val  in  XLEN  exception value
execute_exception_valid  in  1  entry faulted
execute_store_addr  in  XLEN  store address
execute_store_val  in  XLEN  store data
execute_store_size  in  2  store size
execute_store_valid  in  1  entry is a store
execute_csr_write_addr  in  12  CSR address
execute_csr_write_val  in  XLEN  CSR data
execute_csr_write_valid  in  1  entry writes a CSR
datafifo_full  in  1  data FIFO cannot accept
datafifo_addr_out / datafifo_val_out  out  XLEN  store address / data
datafifo_size_out  out  2  store size
datafifo_valid_out  out  1  store push strobe
exception_num_out  out  6  cause
exception_val_out / exception_pc_out  out  XLEN  value / PC of faulting entry
exception_valid_out  out  1  exception strobe
rd_out  out  5  writeback register
rd_val_out  out  XLEN  writeback value
rd_valid_out  out  1  writeback strobe
commit_valid  out  1  head entry retired this cycle
pipeline_flush  out  1  discard younger work and refetch
pipeline_pc  out  XLEN  refetch target
active_rd  out  32  one-hot of every queued, unretired rd != 0
instret  out  64  retired-instruction count
axil_csr_awaddr  out  12; axil_csr_awvalid  out  1; axil_csr_awready  in  1
axil_csr_wdata  out  XLEN; axil_csr_wvalid  out  1; axil_csr_wready  in  1
axil_csr_bresp  in  2; axil_csr_bvalid  in  1; axil_csr_bready  out  1

Behaviour:
- Reset (reset low, async): queue empty, count 0, instret 0, CSR FSM in IDLE. All outputs 0 except execute_ready=1.
- Push when execute_valid && execute_ready, with execute_ready = (count<DEPTH) || commit_valid. A push and a pop in the same cycle leave count unchanged. A pushed entry reaches the head no earlier than the next cycle.
- Head kind, evaluated in this priority order:
  - empty → NODATA
  - exception_valid → EXCEPTION
  - store_valid && datafifo_full → WAIT_FIFO
  - csr_write_valid → WAIT_CSRW
  - otherwise → COMMIT
- COMMIT: commit_valid=1; rd_valid_out=(rd!=0); datafifo_valid_out=store_valid; pipeline_flush=jump_valid, pipeline_pc=jump_pc. Pop.
- EXCEPTION: exception_valid_out=1 with the head's num/val/pc; commit_valid=1; pipeline_flush=1. No rd write, no store. Pop.
- WAIT_FIFO: nothing retires; the head is held.
- CSR FSM states:
  - IDLE → AW_W when head is WAIT_CSRW.
  - AW_W: awvalid and wvalid assert together. Each drops independently on its own ready. Go to BRESP once both handshakes are done; same-cycle readys are allowed.
  - BRESP: bready=1. On bvalid, latch fault=(bresp!=0) and go to CSR_COMMIT.
  - CSR_COMMIT, one cycle: commit_valid=1, pop, then IDLE.
    - No fault: rd_valid_out=(rd!=0).
    - Fault: exception_valid_out=1, num=EXC_CSR_FAULT, val=0, pc=head PC, pipeline_flush=1.
- A flush empties the whole queue on the same edge as the pop. A push in the flush cycle is dropped.
- active_rd excludes the head when it retires this cycle.
- instret increments by 1 on every commit_valid without exception_valid_out; wraps modulo 2^64.

Test Plan:
- Push 3 ALU entries (rd=5/6/0, vals 0x11/0x22/0x33) back to back, DEPTH=2 → execute_ready held 1; rd_valid_out for x5 then x6 on consecutive cycles, none for x0; instret=3.
- Store at head with datafifo_full=1 for 4 cycles → no commit for 4 cycles and queue full (execute_ready=0); single datafifo_valid_out pulse after full drops.
- Jump entry (jump_pc=0x100) followed by a queued ALU entry → pipeline_flush=1, pipeline_pc=0x100; the younger entry never writes back; a push in the flush cycle is dropped.
- CSR write 0x300 with awready one cycle after wready, bresp=0 → awvalid/wvalid overlap correctly; CSR_COMMIT writes rd; active_rd bit set until commit.
- CSR write with bresp=2 → exception_valid_out=1, num=2, flush, instret unchanged.
- Assert reset low mid-BRESP → async clear: queue empty, bready=0, instret=0.
